// File: rtl/apb_uart_tx_sequencer_if.sv
// APB bus bundle between the TX sequencer (master) and the UART register block (slave).
interface apb_uart_tx_sequencer_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_tx_sequencer.sv
// Drains a byte stream into the APB UART: each byte is a STATUS poll followed by a
// WRITE_DATA transfer; BAUD_RATE writes are issued on request and take priority.
module apb_uart_tx_sequencer #(
  parameter logic [11:0] BASE_ADDR  = 12'h600,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic                        pclk,
  input  logic                        preset_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  input  logic [15:0]                 cfg_baud,
  input  logic                        cfg_load,
  input  logic                        err_clr,
  apb_uart_tx_sequencer_if.master     apb,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_slv,
  output logic                        err_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] ADDR_DATA = {20'h0, BASE_ADDR};
  localparam logic [31:0] ADDR_BAUD = {20'h0, BASE_ADDR + 12'h4};
  localparam logic [31:0] ADDR_STAT = {20'h0, BASE_ADDR + 12'h6};

  typedef enum logic [2:0] {
    IDLE, B_SETUP, B_ACCESS, P_SETUP, P_ACCESS, W_SETUP, W_ACCESS
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q;
  logic           push, pop;
  logic           baud_pend, baud_done;
  logic [15:0]    baud_reg;
  logic           wr_pend_q, wr_pend_d;
  logic [15:0]    poll_cnt_q, poll_cnt_d;
  logic           set_slv, set_to;
  logic           psel_q, penable_q, pwrite_q;
  logic           psel_d, penable_d, pwrite_d;
  logic [31:0]    paddr_q, paddr_d;
  logic [15:0]    pwdata_q, pwdata_d;
  logic           unused_prdata;

  assign unused_prdata = ^apb.prdata[15:1];

  assign push       = in_valid && in_ready;
  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0) || baud_pend;

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  // Next-state, FIFO pop / error set strobes and next APB output values.
  always_comb begin
    state_d    = state_q;
    wr_pend_d  = wr_pend_q;
    poll_cnt_d = poll_cnt_q;
    pop        = 1'b0;
    baud_done  = 1'b0;
    set_slv    = 1'b0;
    set_to     = 1'b0;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    pwrite_d   = 1'b0;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;

    case (state_q)
      IDLE: begin
        // A confirmed-idle poll is followed by its data write before anything else.
        if (wr_pend_q)             state_d = W_SETUP;
        else if (baud_pend)        state_d = B_SETUP;
        else if (count_q != '0)    state_d = P_SETUP;
      end
      B_SETUP: state_d = B_ACCESS;
      B_ACCESS: begin
        if (apb.pready) begin
          baud_done = 1'b1;
          set_slv   = apb.pslverr;
          state_d   = IDLE;
        end
      end
      P_SETUP: begin
        poll_cnt_d = poll_cnt_q + 16'd1;
        state_d    = P_ACCESS;
      end
      P_ACCESS: begin
        if (apb.pready) begin
          state_d = IDLE;
          if (apb.pslverr) begin
            set_slv    = 1'b1;
            pop        = 1'b1;
            poll_cnt_d = '0;
          end else if (!apb.prdata[0]) begin
            poll_cnt_d = '0;
            wr_pend_d  = 1'b1;
          end else if (poll_cnt_q == 16'(POLL_LIMIT)) begin
            set_to     = 1'b1;
            pop        = 1'b1;
            poll_cnt_d = '0;
          end
        end
      end
      W_SETUP: begin
        wr_pend_d = 1'b0;
        state_d   = W_ACCESS;
      end
      W_ACCESS: begin
        if (apb.pready) begin
          pop     = 1'b1;
          set_slv = apb.pslverr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      B_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = ADDR_BAUD;
        pwdata_d = baud_reg;
      end
      B_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        pwrite_d  = 1'b1;
      end
      P_SETUP: begin
        psel_d  = 1'b1;
        paddr_d = ADDR_STAT;
      end
      P_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      W_SETUP: begin
        psel_d   = 1'b1;
        pwrite_d = 1'b1;
        paddr_d  = ADDR_DATA;
        pwdata_d = {8'h00, mem[rd_ptr]};
      end
      W_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        pwrite_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state, APB output registers and per-byte bookkeeping.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      wr_pend_q  <= 1'b0;
      poll_cnt_q <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_pend_q  <= wr_pend_d;
      poll_cnt_q <= poll_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
    end
  end

  // Baud request: a load in the completing cycle keeps the request alive.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      baud_pend <= 1'b0;
      baud_reg  <= '0;
    end else begin
      if (cfg_load)       baud_pend <= 1'b1;
      else if (baud_done) baud_pend <= 1'b0;
      if (cfg_load)       baud_reg  <= cfg_baud;
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      err_slv     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (set_slv)      err_slv <= 1'b1;
      else if (err_clr) err_slv <= 1'b0;
      if (set_to)       err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_apb_uart_tx_sequencer.sv
// Scoreboarded bench for apb_uart_tx_sequencer with a scriptable APB UART slave model.
module tb_apb_uart_tx_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PL    = 4;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] cfg_baud = 16'h0000;
  logic        cfg_load = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        err_slv;
  logic        err_timeout;

  apb_uart_tx_sequencer_if apb ();

  apb_uart_tx_sequencer #(
    .BASE_ADDR (12'h600),
    .FIFO_DEPTH(DEPTH),
    .POLL_LIMIT(PL)
  ) dut (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cfg_baud   (cfg_baud),
    .cfg_load   (cfg_load),
    .err_clr    (err_clr),
    .apb        (apb),
    .busy       (busy),
    .fifo_count (fifo_count),
    .err_slv    (err_slv),
    .err_timeout(err_timeout)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [15:0] data;
  } xfer_t;

  xfer_t expq[$];
  int checks = 0;
  int errors = 0;

  // Slave model controls
  int busy_left     = 0;
  bit always_busy   = 1'b0;
  int wait_states   = 0;
  bit hold          = 1'b0;
  bit hold_writes   = 1'b0;
  int slverr_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_read();
    xfer_t t;
    t.addr = 32'h606; t.wr = 1'b0; t.data = 16'h0000;
    expq.push_back(t);
  endfunction

  function automatic void exp_write(input logic [31:0] a, input logic [15:0] d);
    xfer_t t;
    t.addr = a; t.wr = 1'b1; t.data = d;
    expq.push_back(t);
  endfunction

  function automatic void exp_byte(input logic [7:0] b);
    exp_read();
    exp_write(32'h600, {8'h00, b});
  endfunction

  // APB slave: responds just after each rising edge
  initial begin
    int wcnt;
    wcnt = 0;
    apb.pready  = 1'b0;
    apb.prdata  = 16'h0000;
    apb.pslverr = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (apb.psel && !apb.penable) begin
        wcnt = wait_states;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
      end else if (apb.psel && apb.penable) begin
        if (hold || (hold_writes && apb.pwrite)) begin
          apb.pready = 1'b0;
        end else if (wcnt > 0) begin
          apb.pready = 1'b0;
          wcnt--;
        end else begin
          apb.pready = 1'b1;
          if (!apb.pwrite) begin
            apb.prdata  = (always_busy || busy_left > 0) ? 16'h0001 : 16'h0000;
            apb.pslverr = 1'b0;
            if (busy_left > 0) busy_left--;
          end else begin
            apb.pslverr = (apb.paddr == 32'h600) && (slverr_writes > 0);
            if (apb.pslverr) slverr_writes--;
          end
        end
      end else begin
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
      end
    end
  end

  // Monitor: checks SETUP->ACCESS stability and scores each completed transfer
  initial begin
    logic [31:0] cap_addr;
    logic [15:0] cap_data;
    logic        cap_wr;
    xfer_t       e;
    cap_addr = '0; cap_data = '0; cap_wr = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset_n) begin
        if (apb.psel && !apb.penable) begin
          cap_addr = apb.paddr;
          cap_data = apb.pwdata;
          cap_wr   = apb.pwrite;
        end else if (apb.psel && apb.penable) begin
          check("access_stable", {15'h0, apb.pwrite, apb.pwdata, apb.paddr},
                {15'h0, cap_wr, cap_data, cap_addr});
          if (apb.pready) begin
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_xfer: got addr 0x%0h wr %0b data 0x%0h, expected none",
                       apb.paddr, apb.pwrite, apb.pwdata);
            end else begin
              e = expq.pop_front();
              check("xfer_addr", 64'(apb.paddr), 64'(e.addr));
              check("xfer_write", 64'(apb.pwrite), 64'(e.wr));
              if (e.wr) check("xfer_wdata", 64'(apb.pwdata), 64'(e.data));
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit load, input logic [15:0] baud);
    int n;
    n = 0;
    @(negedge pclk);
    in_valid = 1'b1;
    in_data  = b;
    if (load) begin
      cfg_load = 1'b1;
      cfg_baud = baud;
    end
    while (!in_ready && n < 2000) begin
      @(negedge pclk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready 0 for %0d cycles, expected acceptance", n);
    end
    @(posedge pclk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while ((busy || expq.size() != 0) && n < 3000);
    check({name, "_queue_empty"}, 64'(expq.size()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic pulse_clr();
    @(negedge pclk);
    err_clr = 1'b1;
    @(posedge pclk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ps, pe, pw;
    int n;
    bit saw;

    // Reset state
    repeat (2) @(negedge pclk);
    check("rst_psel", 64'(apb.psel), 64'd0);
    check("rst_penable", 64'(apb.penable), 64'd0);
    check("rst_pwrite", 64'(apb.pwrite), 64'd0);
    check("rst_paddr", 64'(apb.paddr), 64'd0);
    check("rst_pwdata", 64'(apb.pwdata), 64'd0);
    check("rst_flags", {62'h0, err_slv, err_timeout}, 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);
    check("idle_psel", 64'(apb.psel), 64'd0);

    // Single byte: latency and six-cycle transfer shape
    exp_byte(8'hA5);
    push(8'hA5, 1'b0, 16'h0);
    ps = '0; pe = '0; pw = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge pclk);
      if (i == 0) check("single_count_after_push", 64'(fifo_count), 64'd1);
      ps = {ps[5:0], apb.psel};
      pe = {pe[5:0], apb.penable};
      pw = {pw[5:0], apb.pwrite};
    end
    check("single_psel_shape", 64'(ps), 64'(7'b0110110));
    check("single_penable_shape", 64'(pe), 64'(7'b0010010));
    check("single_pwrite_shape", 64'(pw), 64'(7'b0000110));
    check("single_count_end", 64'(fifo_count), 64'd0);
    wait_drain("single");

    // Baud write preempts queued data
    exp_write(32'h604, 16'h0145);
    exp_byte(8'h10);
    exp_byte(8'h11);
    exp_byte(8'h12);
    push(8'h10, 1'b1, 16'h0145);
    push(8'h11, 1'b0, 16'h0);
    push(8'h12, 1'b0, 16'h0);
    wait_drain("baud");

    // Busy three times then idle: four reads then the write
    busy_left = 3;
    exp_read(); exp_read(); exp_read();
    exp_byte(8'h3C);
    push(8'h3C, 1'b0, 16'h0);
    wait_drain("poll_busy3");
    check("poll_busy3_no_timeout", 64'(err_timeout), 64'd0);

    // Always busy: four reads, timeout, byte dropped
    always_busy = 1'b1;
    exp_read(); exp_read(); exp_read(); exp_read();
    push(8'h77, 1'b0, 16'h0);
    wait_drain("timeout");
    always_busy = 1'b0;
    check("timeout_flag", 64'(err_timeout), 64'd1);
    check("timeout_count", 64'(fifo_count), 64'd0);
    pulse_clr();
    @(negedge pclk);
    check("timeout_cleared", 64'(err_timeout), 64'd0);

    // FIFO full with stalled poll, then release with wait states
    hold = 1'b1;
    for (int i = 0; i < 9; i++) exp_byte(8'(8'h80 + i));
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i), 1'b0, 16'h0);
    @(negedge pclk);
    check("full_count", 64'(fifo_count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'h88;
    repeat (3) @(negedge pclk);
    check("full_ninth_stalled", 64'(fifo_count), 64'd8);
    wait_states = 2;
    hold = 1'b0;
    push(8'h88, 1'b0, 16'h0);
    wait_drain("full");
    wait_states = 0;

    // Slave error on a data write
    slverr_writes = 1;
    exp_byte(8'h11);
    exp_byte(8'h22);
    push(8'h11, 1'b0, 16'h0);
    push(8'h22, 1'b0, 16'h0);
    wait_drain("slverr");
    check("slverr_flag", 64'(err_slv), 64'd1);
    pulse_clr();
    @(negedge pclk);
    check("slverr_cleared", 64'(err_slv), 64'd0);

    // Clear in the same cycle as a new slave error: set wins
    slverr_writes = 1;
    exp_byte(8'h33);
    push(8'h33, 1'b0, 16'h0);
    n = 0;
    while (!(apb.psel && apb.penable && apb.pwrite && apb.pready) && n < 500) begin
      @(negedge pclk);
      n++;
    end
    check("slverr_clr_reached_write", 64'(apb.pwrite && apb.pready), 64'd1);
    err_clr = 1'b1;
    @(posedge pclk);
    #1;
    err_clr = 1'b0;
    @(negedge pclk);
    check("slverr_set_beats_clr", 64'(err_slv), 64'd1);
    wait_drain("slverr2");
    pulse_clr();
    @(negedge pclk);
    check("slverr2_cleared", 64'(err_slv), 64'd0);

    // Reset during W_ACCESS with four bytes queued
    hold_writes = 1'b1;
    exp_read();
    push(8'h41, 1'b0, 16'h0);
    push(8'h42, 1'b0, 16'h0);
    push(8'h43, 1'b0, 16'h0);
    push(8'h44, 1'b0, 16'h0);
    n = 0;
    while (!(apb.psel && apb.penable && apb.pwrite) && n < 500) begin
      @(negedge pclk);
      n++;
    end
    check("rstmid_in_waccess", 64'(apb.psel && apb.penable && apb.pwrite), 64'd1);
    check("rstmid_count_before", 64'(fifo_count), 64'd4);
    preset_n = 1'b0;
    #1;
    check("rstmid_psel", 64'(apb.psel), 64'd0);
    check("rstmid_penable", 64'(apb.penable), 64'd0);
    check("rstmid_count", 64'(fifo_count), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_poll_scored", 64'(expq.size()), 64'd0);
    hold_writes = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge pclk);
      if (apb.psel) saw = 1'b1;
    end
    check("rstmid_quiet_after_release", 64'(saw), 64'd0);
    exp_byte(8'h5A);
    push(8'h5A, 1'b0, 16'h0);
    wait_drain("after_reset");

    check("final_queue_empty", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
